// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    localparam int DMEM_WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with synchronous write and combinational read
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    // Contents survive reset on purpose; only the port logic is reset.
    logic [31:0] mem [DEPTH_WORDS];

    // Store the word on the commit edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder for the MEM stage
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] req_addr_i,
    input  logic        req_rd_i,
    input  logic        req_wr_i,
    input  logic [31:0] req_wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int OFS_W = $clog2(DMEM_WORD_BYTES);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    op_t                op_q;
    logic               err_q;

    logic               req;
    op_t                req_op;
    logic               req_err;
    logic [IDX_W-1:0]   req_idx;
    logic               commit;
    op_t                cur_op;
    logic               cur_err;
    logic [IDX_W-1:0]   cur_idx;
    logic [31:0]        cur_wdata;
    logic               mem_we;
    logic [31:0]        mem_rdata;

    assign req     = req_rd_i | req_wr_i;
    assign req_op  = req_rd_i ? OP_RD : OP_WR;
    assign req_idx = req_addr_i[IDX_W+OFS_W-1:OFS_W];
    assign req_err = (req_addr_i[OFS_W-1:0] != '0)
                   || ({{OFS_W{1'b0}}, req_addr_i[31:OFS_W]} >= 32'(DEPTH_WORDS))
                   || (req_rd_i & req_wr_i);

    // With LATENCY==1 the commit happens on the accepting edge, before the
    // request has been latched, so the commit path reads the live inputs
    // while in IDLE and the latched copy otherwise.
    assign cur_op    = (state == IDLE) ? req_op      : op_q;
    assign cur_err   = (state == IDLE) ? req_err     : err_q;
    assign cur_idx   = (state == IDLE) ? req_idx     : idx_q;
    assign cur_wdata = (state == IDLE) ? req_wdata_i : wdata_q;

    assign mem_we = commit & (cur_op == OP_WR) & ~cur_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk_i),
        .we    (mem_we),
        .index (cur_idx),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    // Next state, pipeline stall and the commit strobe for the edge into DONE.
    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall_o = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt = DONE;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                    commit    = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latency counter and request capture on acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_q    <= OP_RD;
            err_q   <= 1'b0;
        end else if (state == IDLE && req) begin
            cnt     <= CNT_W'(LATENCY - 1);
            idx_q   <= req_idx;
            wdata_q <= req_wdata_i;
            op_q    <= req_op;
            err_q   <= req_err;
        end else if (state == BUSY) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Completion pulses and load data, all updated on the edge into DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            done_o <= commit;
            err_o  <= commit & cur_err;
            if (commit && cur_op == OP_RD) begin
                rdata_o <= cur_err ? 32'h0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LATENCY 3 and 1
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] req_addr  [2];
    logic        req_rd    [2];
    logic        req_wr    [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rdata     [2];
    logic        stall     [2];
    logic        done      [2];
    logic        err       [2];

    logic [31:0] model [256];
    exp_t        sb [$];
    int          vectors;
    int          miscompares;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut0 (
        .clk_i (clk), .rst_i (rst_i),
        .req_addr_i (req_addr[0]), .req_rd_i (req_rd[0]), .req_wr_i (req_wr[0]),
        .req_wdata_i (req_wdata[0]),
        .rdata_o (rdata[0]), .stall_o (stall[0]), .done_o (done[0]), .err_o (err[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i (clk), .rst_i (rst_i),
        .req_addr_i (req_addr[1]), .req_rd_i (req_rd[1]), .req_wr_i (req_wr[1]),
        .req_wdata_i (req_wdata[1]),
        .rdata_o (rdata[1]), .stall_o (stall[1]), .done_o (done[1]), .err_o (err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input int sel, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " unexpected_done"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, " err"}, 32'(err[sel]), 32'(e.err));
            if (e.chk_data) chk({tag, " rdata"}, rdata[sel], e.data);
        end
    endtask

    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err,
                          input logic chk_data, input string tag);
        int  n;
        bit  seen;
        exp_t e;
        @(negedge clk);
        req_rd[sel] = rd;
        req_wr[sel] = wr;
        req_addr[sel] = addr;
        req_wdata[sel] = wdata;
        e.data = exp_data;
        e.err = exp_err;
        e.chk_data = chk_data;
        sb.push_back(e);
        #1 chk({tag, " stall_c0"}, 32'(stall[sel]), 32'd1);
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (done[sel]) begin
                seen = 1;
                chk({tag, " latency"}, n, (sel == 0) ? 32'd3 : 32'd1);
                chk({tag, " stall_done"}, 32'(stall[sel]), 32'd0);
                pop_check(sel, tag);
            end else begin
                chk({tag, " stall_busy"}, 32'(stall[sel]), 32'd1);
            end
        end
        if (!seen) chk({tag, " timeout"}, 32'd0, 32'd1);
        req_rd[sel] = 1'b0;
        req_wr[sel] = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_i = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_addr[s] = '0;
            req_rd[s] = 1'b0;
            req_wr[s] = 1'b0;
            req_wdata[s] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst rdata", rdata[0], 32'h0);
        chk("rst stall", 32'(stall[0]), 32'd0);
        chk("rst done", 32'(done[0]), 32'd0);
        chk("rst err", 32'(err[0]), 32'd0);
        rst_i = 1'b0;

        // Preload every word through the port; top bit set keeps all words nonzero.
        for (int i = 0; i < 256; i++) begin
            model[i] = $urandom | 32'h8000_0000;
            access(0, 1'b0, 1'b1, 32'(i * 4), model[i], 32'h0, 1'b0, 1'b0, "preload");
        end

        // Store then load.
        model[4] = 32'hDEADBEEF;
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "store10");
        chk("mem10", dut0.u_array.mem[4], 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "load10");

        // Asynchronous reset between clock edges clears outputs at once.
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        chk("async rdata", rdata[0], 32'h0);
        chk("async stall", 32'(stall[0]), 32'd0);
        chk("async done", 32'(done[0]), 32'd0);
        chk("async err", 32'(err[0]), 32'd0);
        #1 rst_i = 1'b0;

        // Errors: misaligned load zeroes rdata, out-of-range store writes nothing.
        access(0, 1'b1, 1'b0, 32'h8, 32'h0, model[2], 1'b0, 1'b1, "load08");
        access(0, 1'b1, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1'b1, "misaligned");
        access(0, 1'b0, 1'b1, 32'h400, 32'h5555AAAA, 32'h0, 1'b1, 1'b0, "oob_store");
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("oob mem[%0d]", i), dut0.u_array.mem[i], model[i]);
        end

        // Reset during BUSY discards the pending store.
        @(negedge clk);
        req_wr[0] = 1'b1;
        req_addr[0] = 32'h20;
        req_wdata[0] = 32'h1234;
        @(negedge clk);
        chk("midrst busy stall", 32'(stall[0]), 32'd1);
        rst_i = 1'b1;
        req_wr[0] = 1'b0;
        #1;
        chk("midrst state", 32'(dut0.state), 32'(IDLE));
        chk("midrst stall", 32'(stall[0]), 32'd0);
        chk("midrst done", 32'(done[0]), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst mem20", dut0.u_array.mem[8], model[8]);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, model[8], 1'b0, 1'b1, "midrst load20");

        // Idle cycles add no stall; conflicting rd+wr is an error with no write.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle stall c%0d", c), 32'(stall[0]), 32'd0);
            chk($sformatf("idle done c%0d", c), 32'(done[0]), 32'd0);
        end
        access(0, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, "rdwr");
        chk("rdwr mem30", dut0.u_array.mem[12], model[12]);

        // LATENCY=1 instance: preload 5 and 7, then two loads with rd held.
        access(1, 1'b0, 1'b1, 32'h0, 32'd5, 32'h0, 1'b0, 1'b0, "l1 pre0");
        access(1, 1'b0, 1'b1, 32'h4, 32'd7, 32'h0, 1'b0, 1'b0, "l1 pre4");
        @(negedge clk);
        req_rd[1] = 1'b1;
        req_addr[1] = 32'h0;
        sb.push_back('{data: 32'd5, err: 1'b0, chk_data: 1'b1});
        #1 chk("b2b c0 stall", 32'(stall[1]), 32'd1);
        @(negedge clk);
        chk("b2b c1 done", 32'(done[1]), 32'd1);
        chk("b2b c1 stall", 32'(stall[1]), 32'd0);
        pop_check(1, "b2b first");
        req_addr[1] = 32'h4;
        sb.push_back('{data: 32'd7, err: 1'b0, chk_data: 1'b1});
        @(negedge clk);
        chk("b2b c2 done", 32'(done[1]), 32'd0);
        chk("b2b c2 stall", 32'(stall[1]), 32'd1);
        @(negedge clk);
        chk("b2b c3 done", 32'(done[1]), 32'd1);
        pop_check(1, "b2b second");
        req_rd[1] = 1'b0;
        @(negedge clk);
        chk("b2b c4 done", 32'(done[1]), 32'd0);
        chk("b2b c4 stall", 32'(stall[1]), 32'd0);
        chk("sb empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
